// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial two's-complement adder/subtractor. It computes S = A + B or
// S = A - B (as A + ~B + 1). One full-adder slice processes one bit per
// clock, LSB first, so a result takes WIDTH + 2 cycles from accept to the
// next possible accept.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     operation request, only looked at while idle
//   sub       0: S = A + B, 1: S = A - B (captured with start)
//   a, b      operands (captured with start)
//   busy      high while an operation is shifting or completing
//   done      one-cycle pulse, s/cout/overflow valid
//   s         result bits (modulo 2^WIDTH)
//   cout      carry out of the MSB slice (for subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_c;

  // The single full-adder slice working on the current LSBs.
  assign fa_sum = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // On the MSB step carry_q is the carry into the MSB and fa_c the
          // carry out of it, so the flags can be registered directly here.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed bench for serial_addsub at WIDTH = 4: reset state, hand-computed
// add/subtract cases, start held high, reset mid-operation and a sweep of
// every (a, b, sub) combination against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check latency, results and pulse width.
  task automatic run_op(input string tag, input logic op_sub,
                        input logic [3:0] op_a, input logic [3:0] op_b,
                        input logic [3:0] exp_s, input logic exp_c,
                        input logic exp_v, input bit verbose);
    int n;
    sub   = op_sub;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Operands may change freely after the accepting edge.
    a     = ~op_a;
    b     = ~op_b;
    sub   = ~op_sub;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
    chk({tag, "_s"}, 32'(s), 32'(exp_s));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
    tick();
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_s_hold"}, 32'(s), 32'(exp_s));
    if (verbose)
      $display("op %s sub=%0d a=%b b=%b -> s=%b cout=%0d ovf=%0d",
               tag, op_sub, op_a, op_b, s, cout, overflow);
  endtask

  initial begin
    logic [3:0] sched_a [3];
    logic [3:0] bb;
    logic [4:0] full;
    logic [3:0] low;
    logic [3:0] ea;
    int         seen_done;

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Hand-computed directed cases.
    run_op("add_0111_0001", 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1);
    run_op("sub_0101_0011", 1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b1);
    run_op("sub_1000_0001", 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b1);
    run_op("add_1111_0001", 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_0000_0001", 1'b1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Start held high with a changing every edge: one accept every 6 edges.
    sub   = 1'b0;
    b     = 4'b0011;
    start = 1'b1;
    for (int e = 0; e < 18; e++) begin
      a = 4'((e * 5 + 1) & 15);
      if (e % 6 == 0) sched_a[e / 6] = a;
      tick();
      chk($sformatf("held_busy_e%0d", e), 32'(busy), 32'((e % 6) != 5));
      chk($sformatf("held_done_e%0d", e), 32'(done), 32'((e % 6) == 4));
      if (e % 6 == 4) begin
        ea = sched_a[e / 6] + 4'b0011;
        chk($sformatf("held_s_e%0d", e), 32'(s), 32'(ea));
        $display("held op %0d a=%b b=0011 -> s=%b", e / 6, sched_a[e / 6], s);
      end
    end
    start = 1'b0;
    tick();

    // Reset two cycles after start aborts with no done pulse.
    sub   = 1'b0;
    a     = 4'b0110;
    b     = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    $display("abort: reset mid-operation, done pulses afterwards=%0d", seen_done);
    run_op("after_abort", 1'b0, 4'b0110, 4'b0101, 4'b1011, 1'b0, 1'b1, 1'b1);

    // Exhaustive sweep against an arithmetic reference.
    for (int k = 0; k < 512; k++) begin
      logic       ts;
      logic [3:0] ta;
      logic [3:0] tb;
      logic       c3;
      ts   = k[8];
      ta   = k[7:4];
      tb   = k[3:0];
      bb   = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, bb} + {4'b0, ts};
      low  = {1'b0, ta[2:0]} + {1'b0, bb[2:0]} + {3'b0, ts};
      c3   = low[3];
      run_op($sformatf("sweep_%0d", k), ts, ta, tb, full[3:0], full[4],
             c3 ^ full[4], 1'b0);
    end
    $display("sweep: 512 operations issued");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case the design never completes.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time bound reached");
  end

endmodule
